// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
//============================================================================
// Module : cpu_control_unit_pkg
// Desc   : Opcode values, control-field encodings and the NOP control vector
//          shared by the RV32I-subset control unit.
// Rev    : 1.0 - initial release
//============================================================================
package cpu_control_unit_pkg;

    // opcode[6:2] of the supported instruction classes
    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_IALU   = 5'b00100;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_RTYPE  = 5'b01100;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;

    localparam logic [2:0] c_F3_BEQ = 3'b000;
    localparam logic [2:0] c_F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        c_IMM_I = 2'b00,
        c_IMM_S = 2'b01,
        c_IMM_B = 2'b10,
        c_IMM_J = 2'b11
    } imm_sel_e;

    typedef enum logic [1:0] {
        c_WB_ALU = 2'b00,
        c_WB_MEM = 2'b01,
        c_WB_PC4 = 2'b10,
        c_WB_IMM = 2'b11
    } mem_to_reg_e;

    typedef enum logic [2:0] {
        c_ALU_AND = 3'b000,
        c_ALU_OR  = 3'b001,
        c_ALU_ADD = 3'b010,
        c_ALU_XOR = 3'b011,
        c_ALU_SRL = 3'b101,
        c_ALU_SUB = 3'b110,
        c_ALU_SLT = 3'b111
    } alu_op_e;

    // What the main decoder tells the ALU decoder about the instruction
    typedef enum logic [1:0] {
        c_CLS_ADD  = 2'b00,
        c_CLS_SUB  = 2'b01,
        c_CLS_RALU = 2'b10,
        c_CLS_IALU = 2'b11
    } alu_class_e;

    typedef struct packed {
        imm_sel_e    imm_sel;
        logic        alu_src_b;
        mem_to_reg_e mem_to_reg;
        logic        jump;
        logic        branch;
        logic        inverse_branch;
        logic        reg_write;
        logic        mem_rw;
        alu_op_e     alu_control;
        logic        cpu_mio;
    } ctrl_t;

    localparam ctrl_t c_NOP_CTRL = '0;

endpackage : cpu_control_unit_pkg
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
//============================================================================
// Module : cpu_control_unit_if
// Desc   : Instruction fields in, decoded datapath controls out.
// Rev    : 1.0 - initial release
//============================================================================
interface cpu_control_unit_if;

    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       MIO_ready;

    logic [1:0] ImmSel;
    logic       ALUSrc_B;
    logic [1:0] MemtoReg;
    logic       Jump;
    logic       Branch;
    logic       InverseBranch;
    logic       RegWrite;
    logic       MemRW;
    logic [2:0] ALU_Control;
    logic       CPU_MIO;

    modport master (
        output OPcode, Fun3, Fun7, MIO_ready,
        input  ImmSel, ALUSrc_B, MemtoReg, Jump, Branch, InverseBranch,
               RegWrite, MemRW, ALU_Control, CPU_MIO
    );

    modport slave (
        input  OPcode, Fun3, Fun7, MIO_ready,
        output ImmSel, ALUSrc_B, MemtoReg, Jump, Branch, InverseBranch,
               RegWrite, MemRW, ALU_Control, CPU_MIO
    );

endinterface : cpu_control_unit_if
`default_nettype wire

// File: rtl/cpu_control_unit_alu_decoder.sv
`default_nettype none
//============================================================================
// Module : alu_decoder
// Desc   : Combinational map of (instruction class, funct3, instr[30]) to ALU op.
// Rev    : 1.0 - initial release
//============================================================================
module alu_decoder
    import cpu_control_unit_pkg::*;
(
    input  alu_class_e i_alu_class,
    input  logic [2:0] i_fun3,
    input  logic       i_fun7,
    output alu_op_e    o_alu_op
);

    always_comb begin
        o_alu_op = c_ALU_ADD;
        case (i_alu_class)
            c_CLS_SUB: o_alu_op = c_ALU_SUB;
            c_CLS_RALU: begin
                case ({i_fun7, i_fun3})
                    4'b1000: o_alu_op = c_ALU_SUB;
                    4'b0111: o_alu_op = c_ALU_AND;
                    4'b0110: o_alu_op = c_ALU_OR;
                    4'b0100: o_alu_op = c_ALU_XOR;
                    4'b0010: o_alu_op = c_ALU_SLT;
                    4'b0101: o_alu_op = c_ALU_SRL;
                    default: o_alu_op = c_ALU_ADD;
                endcase
            end
            c_CLS_IALU: begin
                // instr[30] is immediate data except on shifts, where it selects SRA
                case (i_fun3)
                    3'b111:  o_alu_op = c_ALU_AND;
                    3'b110:  o_alu_op = c_ALU_OR;
                    3'b100:  o_alu_op = c_ALU_XOR;
                    3'b010:  o_alu_op = c_ALU_SLT;
                    3'b101:  o_alu_op = i_fun7 ? c_ALU_ADD : c_ALU_SRL;
                    default: o_alu_op = c_ALU_ADD;
                endcase
            end
            default: o_alu_op = c_ALU_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
//============================================================================
// Module : cpu_control_unit
// Desc   : Main + ALU decoder for the RV32I-subset CPU, registered decode stage.
// Rev    : 1.0 - initial release
//============================================================================
module cpu_control_unit
    import cpu_control_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cpu_control_unit_if.slave  bus
);

    alu_class_e w_alu_class;
    alu_op_e    w_alu_op;
    ctrl_t      w_ctrl;
    ctrl_t      r_ctrl;
    logic       w_unused_mio_ready;

    assign w_unused_mio_ready = bus.MIO_ready;

    always_comb begin
        w_alu_class = c_CLS_ADD;
        case (bus.OPcode)
            c_OP_RTYPE:  w_alu_class = c_CLS_RALU;
            c_OP_IALU:   w_alu_class = c_CLS_IALU;
            c_OP_BRANCH: w_alu_class = c_CLS_SUB;
            default:     w_alu_class = c_CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_class (w_alu_class),
        .i_fun3      (bus.Fun3),
        .i_fun7      (bus.Fun7),
        .o_alu_op    (w_alu_op)
    );

    always_comb begin
        w_ctrl = c_NOP_CTRL;
        case (bus.OPcode)
            c_OP_RTYPE: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_control = w_alu_op;
            end
            c_OP_IALU: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_b   = 1'b1;
                w_ctrl.alu_control = w_alu_op;
            end
            c_OP_LOAD: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_b   = 1'b1;
                w_ctrl.mem_to_reg  = c_WB_MEM;
                w_ctrl.alu_control = w_alu_op;
                w_ctrl.cpu_mio     = 1'b1;
            end
            c_OP_STORE: begin
                w_ctrl.imm_sel     = c_IMM_S;
                w_ctrl.alu_src_b   = 1'b1;
                w_ctrl.mem_rw      = 1'b1;
                w_ctrl.alu_control = w_alu_op;
                w_ctrl.cpu_mio     = 1'b1;
            end
            c_OP_BRANCH: begin
                // Only BEQ/BNE exist here; other compares fall back to NOP
                if (bus.Fun3 == c_F3_BEQ || bus.Fun3 == c_F3_BNE) begin
                    w_ctrl.branch         = 1'b1;
                    w_ctrl.inverse_branch = (bus.Fun3 == c_F3_BNE);
                    w_ctrl.imm_sel        = c_IMM_B;
                    w_ctrl.alu_control    = w_alu_op;
                end
            end
            c_OP_JAL: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.imm_sel    = c_IMM_J;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = c_WB_PC4;
            end
            c_OP_LUI: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.mem_to_reg  = c_WB_IMM;
                w_ctrl.alu_src_b   = 1'b1;
                w_ctrl.alu_control = w_alu_op;
            end
            default: w_ctrl = c_NOP_CTRL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= c_NOP_CTRL;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign bus.ImmSel        = r_ctrl.imm_sel;
    assign bus.ALUSrc_B      = r_ctrl.alu_src_b;
    assign bus.MemtoReg      = r_ctrl.mem_to_reg;
    assign bus.Jump          = r_ctrl.jump;
    assign bus.Branch        = r_ctrl.branch;
    assign bus.InverseBranch = r_ctrl.inverse_branch;
    assign bus.RegWrite      = r_ctrl.reg_write;
    assign bus.MemRW         = r_ctrl.mem_rw;
    assign bus.ALU_Control   = r_ctrl.alu_control;
    assign bus.CPU_MIO       = r_ctrl.cpu_mio;

endmodule : cpu_control_unit
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
//============================================================================
// Module : tb_cpu_control_unit
// Desc   : Directed-vector bench for cpu_control_unit with hand-computed controls.
// Rev    : 1.0 - initial release
//============================================================================
module tb_cpu_control_unit;

    // Field order: ImmSel, ALUSrc_B, MemtoReg, Jump, Branch, InverseBranch,
    //              RegWrite, MemRW, ALU_Control, CPU_MIO
    localparam logic [13:0] c_EXP_NOP  = 14'b0;
    localparam logic [13:0] c_EXP_ADD  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    localparam logic [13:0] c_EXP_SUB  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0};
    localparam logic [13:0] c_EXP_AND  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    localparam logic [13:0] c_EXP_OR   = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    localparam logic [13:0] c_EXP_XOR  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 1'b0};
    localparam logic [13:0] c_EXP_SLT  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0};
    localparam logic [13:0] c_EXP_SRL  = {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0};
    localparam logic [13:0] c_EXP_ADDI = {2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    localparam logic [13:0] c_EXP_ANDI = {2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    localparam logic [13:0] c_EXP_SRLI = {2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0};
    localparam logic [13:0] c_EXP_LW   = {2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1};
    localparam logic [13:0] c_EXP_SW   = {2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1};
    localparam logic [13:0] c_EXP_BEQ  = {2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0};
    localparam logic [13:0] c_EXP_BNE  = {2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0};
    localparam logic [13:0] c_EXP_JAL  = {2'b11, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    localparam logic [13:0] c_EXP_LUI  = {2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0};

    logic        clk;
    logic        rst;
    logic [13:0] w_obs;
    int          n_checks;
    int          n_errors;

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign w_obs = {bus.ImmSel, bus.ALUSrc_B, bus.MemtoReg, bus.Jump, bus.Branch,
                    bus.InverseBranch, bus.RegWrite, bus.MemRW, bus.ALU_Control,
                    bus.CPU_MIO};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [13:0] obs,
                               input logic [13:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply_instr(input logic [31:0] instr);
        bus.OPcode = instr[6:2];
        bus.Fun3   = instr[14:12];
        bus.Fun7   = instr[30];
    endtask

    // Present an instruction, clock it in, sample 1 time unit after the edge
    task automatic step_check(input string tag, input logic [31:0] instr,
                              input logic [13:0] exp);
        apply_instr(instr);
        @(posedge clk);
        #1;
        check_value(tag, w_obs, exp);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.MIO_ready = 1'b0;
        apply_instr(32'h002081B3);
        @(posedge clk);
        #1;
        check_value("reset", w_obs, c_EXP_NOP);
        @(posedge clk);
        #1;
        check_value("reset_hold", w_obs, c_EXP_NOP);

        rst = 1'b0;
        step_check("add", 32'h002081B3, c_EXP_ADD);
        // Registered output must hold until the next edge
        apply_instr(32'h402081B3);
        #1;
        check_value("latency_hold", w_obs, c_EXP_ADD);
        @(posedge clk);
        #1;
        check_value("sub", w_obs, c_EXP_SUB);

        step_check("and",  32'h0020F1B3, c_EXP_AND);
        step_check("or",   32'h0020E1B3, c_EXP_OR);
        step_check("xor",  32'h0020C1B3, c_EXP_XOR);
        step_check("slt",  32'h0020A1B3, c_EXP_SLT);
        step_check("srl",  32'h0020D1B3, c_EXP_SRL);
        step_check("sra_r_default", 32'h4020D1B3, c_EXP_ADD);
        step_check("addi", 32'h00100093, c_EXP_ADDI);
        step_check("addi_f7", 32'h40100093, c_EXP_ADDI);
        step_check("andi", 32'h0FF0F093, c_EXP_ANDI);
        step_check("srli", 32'h0010D093, c_EXP_SRLI);
        step_check("srai_default", 32'h4010D093, c_EXP_ADDI);
        step_check("lw",   32'h0080A283, c_EXP_LW);
        step_check("sw",   32'h0050A423, c_EXP_SW);
        step_check("beq",  32'h00208863, c_EXP_BEQ);
        step_check("bne",  32'h00209863, c_EXP_BNE);
        step_check("blt_nop", 32'h0020C863, c_EXP_NOP);
        step_check("jal",  32'h008000EF, c_EXP_JAL);
        step_check("lui",  32'h123452B7, c_EXP_LUI);
        step_check("ecall_nop", 32'h00000073, c_EXP_NOP);
        step_check("jalr_nop",  32'h000080E7, c_EXP_NOP);
        step_check("auipc_nop", 32'h12345297, c_EXP_NOP);

        // Reset asserted together with a valid store
        apply_instr(32'h0050A423);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("reset_over_sw", w_obs, c_EXP_NOP);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_value("resume_sw", w_obs, c_EXP_SW);

        bus.MIO_ready = 1'b1;
        step_check("lw_mio_ready1", 32'h0080A283, c_EXP_LW);
        bus.MIO_ready = 1'b0;
        step_check("lw_mio_ready0", 32'h0080A283, c_EXP_LW);
        bus.MIO_ready = 1'b1;
        step_check("ecall_mio_ready1", 32'h00000073, c_EXP_NOP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_control_unit
`default_nettype wire

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Main decoder plus ALU decoder for the lab's single-issue RV32I subset CPU.
- Takes opcode[6:2], funct3 and instr[30] of the current instruction.
- Produces immediate-select, datapath-mux, branch/jump, register/memory-write and ALU-operation controls.
- Outputs are registered, giving a one-cycle decode-stage register between fetch and execute.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- OPcode  input  5  instruction bits [6:2]
- Fun3  input  3  instruction bits [14:12]
- Fun7  input  1  instruction bit [30]
- MIO_ready  input  1  memory-ready flag; reserved, no effect on outputs
- ImmSel  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrc_B  output  1  ALU operand B: 0 = rs2, 1 = immediate
- MemtoReg  output  2  write-back source: 00 ALU, 01 data memory, 10 PC+4, 11 U-immediate
- Jump  output  1  unconditional jump (JAL)
- Branch  output  1  conditional branch
- InverseBranch  output  1  branch on ALU zero = 0 (BNE) instead of zero = 1 (BEQ)
- RegWrite  output  1  register-file write enable
- MemRW  output  1  data memory: 1 = write, 0 = read
- ALU_Control  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 011 XOR, 101 SRL, 110 SUB, 111 SLT
- CPU_MIO  output  1  memory access in progress (load or store)

Behaviour:
- Decode is combinational from OPcode/Fun3/Fun7; the result is captured into output registers on each rising clk.
- Latency is 1 cycle: outputs reflect the inputs sampled at the previous edge.
- Reset: rst=1 at an edge forces the NOP vector, which is all outputs 0 (ALU_Control=000).
  - Reset overrides decode on that edge.
  - Deasserting rst resumes decode on the next edge.
- R-type, OPcode 01100: RegWrite=1, ALUSrc_B=0, MemtoReg=00, ImmSel=00. ALU_Control by {Fun7,Fun3}:
  - 0000 → ADD
  - 1000 → SUB
  - 0111 → AND
  - 0110 → OR
  - 0100 → XOR
  - 0010 → SLT
  - 0101 → SRL
  - any other combination → ADD
- I-ALU, OPcode 00100: RegWrite=1, ALUSrc_B=1, ImmSel=00, MemtoReg=00. ALU_Control by Fun3:
  - 000 → ADD, regardless of Fun7
  - 111 → AND, 110 → OR, 100 → XOR, 010 → SLT
  - 101 → SRL only when Fun7=0; otherwise ADD
  - other Fun3 values → ADD
- Load, OPcode 00000: RegWrite=1, ALUSrc_B=1, ImmSel=00, MemtoReg=01, ALU=ADD, MemRW=0, CPU_MIO=1.
- Store, OPcode 01000: RegWrite=0, ALUSrc_B=1, ImmSel=01, ALU=ADD, MemRW=1, CPU_MIO=1.
- Branch, OPcode 11000: Branch=1, ImmSel=10, ALUSrc_B=0, ALU=SUB, RegWrite=0.
  - Fun3=000 (BEQ): InverseBranch=0.
  - Fun3=001 (BNE): InverseBranch=1.
  - Other Fun3: NOP vector.
- JAL, OPcode 11011: Jump=1, ImmSel=11, RegWrite=1, MemtoReg=10.
- LUI, OPcode 01101: RegWrite=1, MemtoReg=11, ImmSel=00, ALUSrc_B=1, ALU=ADD.
- Any other OPcode (including JALR, AUIPC, SYSTEM): NOP vector; no register or memory write.
- Every output not listed for a class is 0.
- MemRW and RegWrite are never both 1.

Decomposition:
- Shared package holds the constants:
  - opcode[6:2] values
  - ImmSel, MemtoReg and ALU_Control encodings
  - the NOP control vector as a packed struct
- One sub-module, alu_decoder, is natural: combinational, maps (OPcode class, Fun3, Fun7) → ALU_Control.
- The top level holds the main decoder and the output register.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) and sub x3,x1,x2 (0x402081B3):
  - with rst=1, outputs are all 0 at the next edge;
  - after release: RegWrite=1, ALUSrc_B=0, MemtoReg=00, ALU_Control=010 for ADD and 110 for SUB, each one cycle after application.
- lw x5,8(x1) (0x0080A283) → ALUSrc_B=1, ImmSel=00, MemtoReg=01, RegWrite=1, MemRW=0, CPU_MIO=1, ALU=010.
- sw x5,8(x1) (0x0050A423) → ImmSel=01, ALUSrc_B=1, MemRW=1, RegWrite=0, CPU_MIO=1, ALU=010.
- beq x1,x2,16 (0x00208863) → Branch=1, InverseBranch=0, ImmSel=10, ALU=110, RegWrite=0.
  - bne (0x00209863) gives the same but InverseBranch=1.
- jal x1,8 (0x008000EF) → Jump=1, ImmSel=11, MemtoReg=10, RegWrite=1.
  - lui x5,0x12345 (0x123452B7) → MemtoReg=11, RegWrite=1.
- Unsupported opcode, e.g. ecall (0x00000073) → all outputs 0.
  - Assert rst in the same cycle as a valid sw: outputs 0 next cycle.
  - Toggling MIO_ready changes nothing.
